// File: rtl/csa_byte_gearbox_if.sv
// Stream bundle for csa_byte_gearbox: input word channel, output word channel and status.
// The slave modport is the gearbox view; the master modport is the producer/consumer view.
interface csa_byte_gearbox_if #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned IN_BYTES   = 4,
    parameter int unsigned OUT_BYTES  = 5,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic [IN_BYTES*BYTE_WIDTH-1:0]   in_data;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [OUT_BYTES*BYTE_WIDTH-1:0]  out_data;
    logic [OUT_BYTES-1:0]             out_keep;
    logic                             out_last;
    logic [CNT_WIDTH-1:0]             level;
    logic [CNT_WIDTH-1:0]             drop_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, level, drop_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, level, drop_count
    );
endinterface

// File: rtl/csa_byte_gearbox.sv
// Byte-granular IN_BYTES -> OUT_BYTES gearbox with frame flush (padded partial word or dropped residual).
// Outputs are combinational from the byte buffer; push appends behind any same-cycle pop.
module csa_byte_gearbox #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned IN_BYTES   = 4,
    parameter int unsigned OUT_BYTES  = 5,
    parameter int unsigned BUF_BYTES  = 9,
    parameter bit          PAD_LAST   = 1'b1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic           clk,
    input logic           rst,
    csa_byte_gearbox_if.slave bus
);
    localparam int unsigned LW = $clog2(BUF_BYTES + 1);
    localparam int unsigned DW = CNT_WIDTH + 1;

    if (BUF_BYTES < IN_BYTES + OUT_BYTES - 1) begin : g_buf_check
        $error("csa_byte_gearbox: BUF_BYTES must be >= IN_BYTES+OUT_BYTES-1");
    end

    typedef enum logic {FILL, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [BYTE_WIDTH-1:0]  mem_q [BUF_BYTES];
    logic [BYTE_WIDTH-1:0]  mem_d [BUF_BYTES];
    logic [LW-1:0]          level_q, level_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic [DW-1:0]          dsum;
    logic                   in_ready, push, pop, out_valid, out_last, drop;
    logic [OUT_BYTES-1:0]   keep_mask;
    int unsigned            lvl, nl, base;

    assign lvl = 32'(level_q);

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        keep_mask = '0;
        drop      = 1'b0;
        dsum      = '0;
        in_ready  = (state_q == FILL) && (lvl + IN_BYTES <= BUF_BYTES);

        case (state_q)
            FILL: begin
                out_valid = (lvl >= OUT_BYTES);
                keep_mask = '1;
            end
            default: begin
                if (PAD_LAST) begin
                    out_valid = (lvl > 0);
                    out_last  = (lvl <= OUT_BYTES);
                    for (int unsigned i = 0; i < OUT_BYTES; i++) keep_mask[i] = (i < lvl);
                end else begin
                    out_valid = (lvl >= OUT_BYTES);
                    out_last  = (lvl < 2 * OUT_BYTES);
                    keep_mask = '1;
                    drop      = (lvl > 0) && (lvl < OUT_BYTES);
                end
            end
        endcase

        push = bus.in_valid && in_ready;
        pop  = out_valid && bus.out_ready;

        // A padded last beat may hold fewer than OUT_BYTES, so its pop empties rather than subtracts.
        nl = lvl;
        if (pop) nl = (PAD_LAST && out_last) ? 0 : lvl - OUT_BYTES;
        base = nl;
        if (push) nl = nl + IN_BYTES;
        if (drop) nl = 0;
        level_d = LW'(nl);

        if (state_q == FILL) begin
            if (push && bus.in_last) state_d = FLUSH;
        end else if (nl == 0) begin
            state_d = FILL;
        end

        if (drop) begin
            dsum = {1'b0, drop_q} + DW'(level_q);
            drop_d = dsum[CNT_WIDTH] ? '1 : dsum[CNT_WIDTH-1:0];
        end

        for (int unsigned i = 0; i < BUF_BYTES; i++) mem_d[i] = mem_q[i];
        if (pop) begin
            for (int unsigned i = 0; i < BUF_BYTES - OUT_BYTES; i++) mem_d[i] = mem_q[i + OUT_BYTES];
            for (int unsigned i = BUF_BYTES - OUT_BYTES; i < BUF_BYTES; i++) mem_d[i] = '0;
        end
        if (push) begin
            for (int unsigned i = 0; i < BUF_BYTES; i++)
                for (int unsigned j = 0; j < IN_BYTES; j++)
                    if (i == base + j) mem_d[i] = bus.in_data[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            level_q <= '0;
            drop_q  <= '0;
            for (int unsigned i = 0; i < BUF_BYTES; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            drop_q  <= drop_d;
            for (int unsigned i = 0; i < BUF_BYTES; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int unsigned i = 0; i < OUT_BYTES; i++)
            if (out_valid && keep_mask[i]) bus.out_data[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_q[i];
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_keep   = out_valid ? keep_mask : '0;
    assign bus.out_last   = out_valid && out_last;
    assign bus.level      = CNT_WIDTH'(level_q);
    assign bus.drop_count = drop_q;
endmodule
